// File: rtl/sparse_bitmap_encoder_pkg.sv
// Shared definitions for the sparse match path.
// PREFIX_SUM_SIZE is the default chunk size; chunk_bitmap_t is the bitmap
// type exchanged with the AND/priority-encode match stage.
package sparse_bitmap_encoder_pkg;

    localparam int unsigned PREFIX_SUM_SIZE = 8;
    localparam int unsigned CHUNK_IDX_W     = $clog2(PREFIX_SUM_SIZE);
    localparam int unsigned CHUNK_CNT_W     = CHUNK_IDX_W + 1;

    typedef logic [PREFIX_SUM_SIZE-1:0] chunk_bitmap_t;

endpackage

// File: rtl/sparse_bitmap_encoder.sv
// Producer side of the sparse match path.
// Consumes a dense element stream and, per chunk, emits a non-zero bitmap
// plus a packed stream of the non-zero values tagged with their in-chunk index.
//
// Ports:
//   clk_i, rst_i                 clock (rising edge), async active-low reset
//   in_valid_i/in_ready_o        dense element handshake
//   in_data_i, in_last_i         element, early chunk close
//   val_valid_o/val_ready_i      packed non-zero value handshake
//   val_data_o, val_idx_o        value and its position in the chunk
//   bm_valid_o/bm_ready_i        bitmap handshake (one-deep output register)
//   bm_o, bm_cnt_o               non-zero bitmap and its popcount
//   sub_chunk_start_o            pulses in the cycle a bitmap handshake completes
module sparse_bitmap_encoder
    import sparse_bitmap_encoder_pkg::*;
#(
    parameter  int unsigned CHUNK_SIZE = PREFIX_SUM_SIZE,
    parameter  int unsigned DATA_W     = 8,
    localparam int unsigned IDX_W      = $clog2(CHUNK_SIZE)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_W-1:0]     in_data_i,
    input  logic                  in_last_i,
    output logic                  val_valid_o,
    input  logic                  val_ready_i,
    output logic [DATA_W-1:0]     val_data_o,
    output logic [IDX_W-1:0]      val_idx_o,
    output logic                  bm_valid_o,
    input  logic                  bm_ready_i,
    output logic [CHUNK_SIZE-1:0] bm_o,
    output logic [IDX_W:0]        bm_cnt_o,
    output logic                  sub_chunk_start_o
);

    localparam int unsigned CNT_W = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNK_SIZE - 1);

    logic [IDX_W-1:0]      idx;
    logic [CHUNK_SIZE-1:0] acc;
    logic [CNT_W-1:0]      nz_cnt;

    logic                  nz;
    logic                  close;
    logic                  acc_en;
    logic [CHUNK_SIZE-1:0] acc_next;
    logic [CNT_W-1:0]      cnt_next;

    always_comb begin
        nz    = (in_data_i != '0);
        close = (idx == LAST_IDX) || in_last_i;
        // Stall only when the value slot cannot drain, or when this element
        // closes a chunk while the previous bitmap is still held.
        in_ready_o = (!val_valid_o || val_ready_i) &&
                     !(close && bm_valid_o && !bm_ready_i);
        acc_en   = in_valid_i && in_ready_o;
        acc_next = acc;
        acc_next[idx] = nz;
        cnt_next = nz_cnt + CNT_W'(nz);
    end

    assign sub_chunk_start_o = bm_valid_o && bm_ready_i;

    // Value output register: reload and handshake may coincide.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            val_valid_o <= 1'b0;
            val_data_o  <= '0;
            val_idx_o   <= '0;
        end else if (acc_en && nz) begin
            val_valid_o <= 1'b1;
            val_data_o  <= in_data_i;
            val_idx_o   <= idx;
        end else if (val_ready_i) begin
            val_valid_o <= 1'b0;
        end
    end

    // Chunk accumulator: position, partial bitmap and running popcount.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            idx    <= '0;
            acc    <= '0;
            nz_cnt <= '0;
        end else if (acc_en) begin
            if (close) begin
                idx    <= '0;
                acc    <= '0;
                nz_cnt <= '0;
            end else begin
                idx    <= idx + IDX_W'(1);
                acc    <= acc_next;
                nz_cnt <= cnt_next;
            end
        end
    end

    // Bitmap output register: a close in the handshake cycle loads back-to-back.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bm_valid_o <= 1'b0;
            bm_o       <= '0;
            bm_cnt_o   <= '0;
        end else if (acc_en && close) begin
            bm_valid_o <= 1'b1;
            bm_o       <= acc_next;
            bm_cnt_o   <= cnt_next;
        end else if (bm_ready_i) begin
            bm_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sparse_bitmap_encoder.sv
// Self-checking bench for sparse_bitmap_encoder (CHUNK_SIZE=8, DATA_W=8).
// A queue-based model tracks outstanding values and bitmaps; directed
// scenarios add literal expectations on the delivered streams.
module tb_sparse_bitmap_encoder;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       in_valid;
    logic       in_ready_o;
    logic [7:0] in_data;
    logic       in_last;
    logic       val_valid_o;
    logic       val_ready;
    logic [7:0] val_data_o;
    logic [2:0] val_idx_o;
    logic       bm_valid_o;
    logic       bm_ready;
    logic [7:0] bm_o;
    logic [3:0] bm_cnt_o;
    logic       sub_chunk_start_o;

    int checks = 0;
    int errors = 0;
    int stalls = 0;
    int scs_cnt = 0;
    logic tog_en = 1'b0;

    // Model: pending outputs in order of production.
    logic [7:0] vq_d[$];
    logic [2:0] vq_i[$];
    logic [7:0] bq_m[$];
    logic [3:0] bq_c[$];
    int         m_pos = 0;
    logic [7:0] m_bits = '0;
    int         m_cnt = 0;

    // Delivered-stream logs.
    logic [7:0] lv_d[$];
    logic [2:0] lv_i[$];
    logic [7:0] lb_m[$];
    logic [3:0] lb_c[$];

    sparse_bitmap_encoder #(.CHUNK_SIZE(8), .DATA_W(8)) dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .in_valid_i        (in_valid),
        .in_ready_o        (in_ready_o),
        .in_data_i         (in_data),
        .in_last_i         (in_last),
        .val_valid_o       (val_valid_o),
        .val_ready_i       (val_ready),
        .val_data_o        (val_data_o),
        .val_idx_o         (val_idx_o),
        .bm_valid_o        (bm_valid_o),
        .bm_ready_i        (bm_ready),
        .bm_o              (bm_o),
        .bm_cnt_o          (bm_cnt_o),
        .sub_chunk_start_o (sub_chunk_start_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Compare process: outputs vs model every cycle, then apply the
    // handshakes that the next rising edge will complete.
    always @(negedge clk) begin
        if (!rst_i) begin
            vq_d.delete(); vq_i.delete(); bq_m.delete(); bq_c.delete();
            m_pos = 0; m_bits = '0; m_cnt = 0;
        end else begin
            chk("val_valid", val_valid_o, vq_d.size() != 0);
            if (val_valid_o && vq_d.size() != 0) begin
                chk("val_data", val_data_o, vq_d[0]);
                chk("val_idx", val_idx_o, vq_i[0]);
            end
            chk("bm_valid", bm_valid_o, bq_m.size() != 0);
            if (bm_valid_o && bq_m.size() != 0) begin
                chk("bm", bm_o, bq_m[0]);
                chk("bm_cnt", bm_cnt_o, bq_c[0]);
            end
            chk("sub_chunk_start", sub_chunk_start_o, (bq_m.size() != 0) && bm_ready);

            if (val_valid_o && val_ready) begin
                lv_d.push_back(val_data_o);
                lv_i.push_back(val_idx_o);
                if (vq_d.size() != 0) begin
                    void'(vq_d.pop_front());
                    void'(vq_i.pop_front());
                end
            end
            if (bm_valid_o && bm_ready) begin
                lb_m.push_back(bm_o);
                lb_c.push_back(bm_cnt_o);
                if (sub_chunk_start_o) scs_cnt++;
                if (bq_m.size() != 0) begin
                    void'(bq_m.pop_front());
                    void'(bq_c.pop_front());
                end
            end
            if (in_valid && in_ready_o) begin
                if (in_data != 8'd0) begin
                    vq_d.push_back(in_data);
                    vq_i.push_back(3'(m_pos));
                    m_bits[m_pos] = 1'b1;
                    m_cnt++;
                end
                if (m_pos == 7 || in_last) begin
                    bq_m.push_back(m_bits);
                    bq_c.push_back(4'(m_cnt));
                    m_pos = 0; m_bits = '0; m_cnt = 0;
                end else begin
                    m_pos++;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (tog_en) val_ready = !val_ready;
    end

    task automatic send(input logic [7:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready_o) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            stalls++;
        end
        chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        lv_d.delete(); lv_i.delete(); lb_m.delete(); lb_c.delete();
        scs_cnt = 0;
        stalls  = 0;
    endtask

    initial begin
        logic [7:0] seq1 [8];
        seq1 = '{8'd0, 8'd5, 8'd0, 8'd0, 8'd7, 8'd0, 8'd0, 8'd3};
        rst_i = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        val_ready = 1'b1; bm_ready = 1'b1;

        @(posedge clk); #1;
        chk("rst_val_valid", val_valid_o, 0);
        chk("rst_bm_valid", bm_valid_o, 0);
        chk("rst_bm", bm_o, 0);
        chk("rst_bm_cnt", bm_cnt_o, 0);
        chk("rst_scs", sub_chunk_start_o, 0);
        @(posedge clk); #1;
        rst_i = 1'b1;

        // Sparse chunk 0,5,0,0,7,0,0,3.
        clear_logs();
        for (int i = 0; i < 8; i++) send(seq1[i], 1'b0);
        idle(4);
        chk("t1_nvals", lv_d.size(), 3);
        if (lv_d.size() == 3) begin
            chk("t1_v0", {lv_d[0], 5'd0, lv_i[0]}, {8'd5, 8'd1});
            chk("t1_v1", {lv_d[1], 5'd0, lv_i[1]}, {8'd7, 8'd4});
            chk("t1_v2", {lv_d[2], 5'd0, lv_i[2]}, {8'd3, 8'd7});
        end
        chk("t1_nbm", lb_m.size(), 1);
        if (lb_m.size() == 1) chk("t1_bm", {lb_m[0], lb_c[0]}, {8'b1001_0010, 4'd3});
        chk("t1_scs", scs_cnt, 1);

        // All-zero chunk.
        clear_logs();
        for (int i = 0; i < 8; i++) send(8'd0, 1'b0);
        idle(4);
        chk("t2_nvals", lv_d.size(), 0);
        chk("t2_nbm", lb_m.size(), 1);
        if (lb_m.size() == 1) chk("t2_bm", {lb_m[0], lb_c[0]}, 12'h000);
        chk("t2_scs", scs_cnt, 1);

        // Early close, then a 1-element chunk starting at idx 0.
        clear_logs();
        send(8'd9, 1'b0); send(8'd0, 1'b0); send(8'd4, 1'b1);
        send(8'h11, 1'b1);
        idle(4);
        chk("t3_nbm", lb_m.size(), 2);
        if (lb_m.size() == 2) begin
            chk("t3_bm0", {lb_m[0], lb_c[0]}, {8'b0000_0101, 4'd2});
            chk("t3_bm1", {lb_m[1], lb_c[1]}, {8'b0000_0001, 4'd1});
        end
        chk("t3_nvals", lv_d.size(), 3);
        if (lv_d.size() == 3) chk("t3_v2", {lv_d[2], 5'd0, lv_i[2]}, {8'h11, 8'd0});

        // Bitmap sink stalled across two chunks.
        clear_logs();
        bm_ready = 1'b0;
        send(8'd1, 1'b0); send(8'd0, 1'b0); send(8'd2, 1'b0); send(8'd0, 1'b0);
        send(8'd0, 1'b0); send(8'd0, 1'b0); send(8'd0, 1'b0); send(8'd3, 1'b0);
        send(8'd0, 1'b0); send(8'd4, 1'b0); send(8'd0, 1'b0); send(8'd0, 1'b0);
        send(8'd5, 1'b0); send(8'd0, 1'b0); send(8'd0, 1'b0);
        chk("t4_no_early_stall", stalls, 0);
        in_valid = 1'b1; in_data = 8'd6;
        repeat (3) begin
            @(negedge clk);
            chk("t4_ready_drop", in_ready_o, 0);
            chk("t4_bm_held", {bm_valid_o, bm_o, bm_cnt_o}, {1'b1, 8'b1000_0101, 4'd3});
        end
        @(posedge clk); #1;
        bm_ready = 1'b1;
        @(negedge clk);
        chk("t4_ready_release", in_ready_o, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        idle(4);
        chk("t4_nbm", lb_m.size(), 2);
        if (lb_m.size() == 2) begin
            chk("t4_bm0", {lb_m[0], lb_c[0]}, {8'b1000_0101, 4'd3});
            chk("t4_bm1", {lb_m[1], lb_c[1]}, {8'b1001_0010, 4'd3});
        end
        chk("t4_scs", scs_cnt, 2);

        // Value sink toggling with an all-non-zero chunk.
        clear_logs();
        tog_en = 1'b1;
        for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
        tog_en = 1'b0;
        @(posedge clk); #2;
        val_ready = 1'b1;
        idle(6);
        chk("t5_stalled", stalls > 0, 1);
        chk("t5_nvals", lv_d.size(), 8);
        if (lv_d.size() == 8)
            for (int i = 0; i < 8; i++)
                chk("t5_val", {lv_d[i], 5'd0, lv_i[i]}, {8'(i + 1), 8'(i)});
        chk("t5_nbm", lb_m.size(), 1);
        if (lb_m.size() == 1) chk("t5_bm", {lb_m[0], lb_c[0]}, {8'hFF, 4'd8});

        // Asynchronous reset mid-chunk.
        send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b0);
        chk("t6_pre_valid", {val_valid_o, val_idx_o}, {1'b1, 3'd2});
        #2;
        rst_i = 1'b0;
        #1;
        chk("t6_val_valid", val_valid_o, 0);
        chk("t6_val_data", val_data_o, 0);
        chk("t6_val_idx", val_idx_o, 0);
        chk("t6_bm_valid", bm_valid_o, 0);
        chk("t6_bm", bm_o, 0);
        chk("t6_bm_cnt", bm_cnt_o, 0);
        chk("t6_scs", sub_chunk_start_o, 0);
        @(posedge clk); #1;
        rst_i = 1'b1;
        clear_logs();
        send(8'd0, 1'b0); send(8'd6, 1'b1);
        idle(4);
        chk("t6_nvals", lv_d.size(), 1);
        if (lv_d.size() == 1) chk("t6_v0", {lv_d[0], 5'd0, lv_i[0]}, {8'd6, 8'd1});
        chk("t6_nbm", lb_m.size(), 1);
        if (lb_m.size() == 1) chk("t6_bm", {lb_m[0], lb_c[0]}, {8'b0000_0010, 4'd1});

        chk("end_vq_empty", vq_d.size(), 0);
        chk("end_bq_empty", bq_m.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
